fetch_stage_2w: RTL and testbench
=================================

# fetch_stage_2w

Two-wide instruction fetch stage sitting directly upstream of the instruction buffer. It holds the fetch PC, reads one 8-byte I-cache line per cycle, and extracts up to two 32-bit instructions from it. It registers them into an output packet pair that feeds the buffer's `if_dp_packet_in`. It stalls on I-cache miss or buffer back-pressure, redirects on ROB squash, and optionally predicts JAL targets.

## Interface
Parameters:
- `RESET_PC`, default `32'h0`: PC loaded on reset.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `squash_in` in 1: ROB mispredict redirect.
- `squash_pc_in` in 32: redirect target, 4-byte aligned.
- `buffer_full_in` in 1: driven from the instruction buffer's `buffer_full`.
- `Icache2proc_data` in 64: line data. `[31:0]` is the instruction at line+0; `[63:32]` is the instruction at line+4.
- `Icache2proc_valid` in 1: hit for the address presented this cycle (combinational cache).
- `proc2Icache_addr` out 32: `{fetch_pc[31:3], 3'b000}`, combinational from the PC register.
- `if_dp_packet_out` out `IF_DP_PACKET[1:0]`: registered packets {inst, PC, NPC, valid}.
- `fetch_pc_out` out 32: current PC register, for debug.

## Operation
- Slot extraction from `fetch_pc`:
  - slot0 = instruction at `fetch_pc`.
  - slot1 = instruction at `fetch_pc+4`, only if `fetch_pc[2]==0`.
  - When `fetch_pc[2]==1`, only slot0 is used and it is taken from `data[63:32]`.
- Sequential NPC for each slot is its PC+4. `next_pc` is `fetch_pc+8` for two slots and `fetch_pc+4` for one.
- `occupied` = either output slot valid.
- `advance` = `Icache2proc_valid & !squash_in & (!buffer_full_in | !occupied)`.
- Register update at each edge, in priority order:
  1. `squash_in`: `fetch_pc <= squash_pc_in`. Both out slots are cleared (valid=0, inst=`NOP`, PC=NPC=0).
  2. `advance`: out slots are loaded with the extracted packets. `fetch_pc <= next_pc`.
  3. `!buffer_full_in`: out slots are cleared, because the buffer consumed them this edge. `fetch_pc` holds (miss).
  4. Otherwise, all state holds (back-pressure).
- Output-register view as a state machine:
  - EMPTY → LOADED on `advance`.
  - LOADED → LOADED on `advance`.
  - LOADED → EMPTY on miss without full, or on squash.
  - LOADED holds while `buffer_full_in`.
- Valid slots are always packed from slot0. Pattern {slot0=0, slot1=1} never occurs.
- PC arithmetic is 32-bit modulo. Wrap from `32'hFFFF_FFFC` to 0 is legal.

## Timing
- Latency is 1 cycle: a hit at cycle N appears on `if_dp_packet_out` at N+1.
- Sustained throughput: 2 instructions/cycle when aligned and the buffer has room.
- Redirect: squash at cycle N puts the target on `proc2Icache_addr` at N+1. The earliest target packet is at N+2.
- Squash takes priority over hit, miss and full in the same cycle.
- Async reset, including mid-miss or mid-stall, immediately sets:
  - `fetch_pc = RESET_PC`;
  - both slots invalid with inst=`NOP`, PC=NPC=0;
  - `proc2Icache_addr = {RESET_PC[31:3],3'b0}`.
- A packet that was valid while `buffer_full_in` was high must be presented unchanged until `buffer_full_in` falls. It is never dropped or duplicated.

## Configuration
- `IF_JAL_PREDICT_EN` defined:
  - A slot whose opcode is `7'b1101111` (JAL) gets NPC = slot PC + sign-extended J-immediate.
  - If slot0 is JAL, slot1 is forced invalid.
  - `next_pc` = the predicted NPC of the last valid slot.
- `IF_JAL_PREDICT_EN` undefined: all NPCs are sequential and JAL is treated like any other instruction.

## Structure
- Shared package `sys_defs` provides `IF_DP_PACKET`, `` `NOP ``, `` `XLEN `` and the JAL opcode constant. The block adds no new typedefs to it.
- One sub-module, `jal_predecode`, is instantiated once per slot. It is purely combinational: it takes inst and PC and returns `is_jal` and `target`. It is only elaborated under `IF_JAL_PREDICT_EN`.

## Test plan
- **Reset and aligned fetch:** `RESET_PC=0`; reset_n low gives addr=0, slots invalid, `fetch_pc_out=0`. Release with a hit on `{32'h00200093,32'h00100093}`. Next cycle: slot0 PC=0, inst=00100093, NPC=4; slot1 PC=4, NPC=8; `fetch_pc_out=8`.
- **Misaligned redirect:** squash with `squash_pc_in=32'h14` gives addr=`32'h10` next cycle. A hit yields only slot0 with PC=0x14, inst=data[63:32], NPC=0x18; `fetch_pc_out=0x18`.
- **Miss:** `Icache2proc_valid=0` for 3 cycles with buffer not full. Slots go invalid after one cycle and PC holds. A hit on cycle 4 produces packets at cycle 5.
- **Back-pressure:** `buffer_full_in=1` for 2 cycles with loaded slots gives identical packets and an unchanged PC. On release, the next line's packets load on the following edge.
- **Squash priority:** squash asserted together with `buffer_full_in=1` and a miss, target `32'h40`. Next cycle: slots invalid and `fetch_pc_out=32'h40`.
- **JAL at PC 0x20, slot0 = `32'h010000EF`:**
  - With `IF_JAL_PREDICT_EN`: slot0 NPC=0x30, slot1 invalid, PC becomes 0x30.
  - Without it: both slots valid, PC becomes 0x28.

Source files
------------

// File: rtl/sys_defs.sv
// Shared definitions for the front end: the fetch-to-dispatch packet, the NOP
// encoding and the JAL opcode. Also provides the `NOP and `XLEN macros.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NOP
`define NOP 32'h0000_0013
`endif

package sys_defs;

    localparam int unsigned XLEN_W     = `XLEN;
    localparam logic [31:0] NOP_INST   = `NOP;
    localparam logic [6:0]  JAL_OPCODE = 7'b1101111;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
        logic        valid;
    } IF_DP_PACKET;

    // An empty slot carries a NOP so a stray read downstream is harmless.
    localparam IF_DP_PACKET EMPTY_PKT = '{inst: NOP_INST, PC: 32'h0, NPC: 32'h0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_2w_jal_predecode.sv
// Combinational JAL detector and target calculator for one fetch slot.
// Only present when IF_JAL_PREDICT_EN is defined.
`ifdef IF_JAL_PREDICT_EN
module jal_predecode
    import sys_defs::*;
(
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic        is_jal_o,
    output logic [31:0] target_o
);

    logic [31:0] j_imm;
    logic        unused_rd;

    // J-type immediate: imm[20|10:1|11|19:12] scattered across inst[31:12].
    assign j_imm     = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign is_jal_o  = (inst_i[6:0] == JAL_OPCODE);
    assign target_o  = pc_i + j_imm;
    assign unused_rd = ^inst_i[11:7];

endmodule
`endif

// File: rtl/fetch_stage_2w.sv
// Two-wide fetch stage: holds the fetch PC, splits an 8-byte I-cache line into
// up to two registered packets. JAL target prediction under IF_JAL_PREDICT_EN.
module fetch_stage_2w
    import sys_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              squash_in,
    input  logic [31:0]       squash_pc_in,
    input  logic              buffer_full_in,
    input  logic [63:0]       Icache2proc_data,
    input  logic              Icache2proc_valid,
    output logic [31:0]       proc2Icache_addr,
    output IF_DP_PACKET [1:0] if_dp_packet_out,
    output logic [31:0]       fetch_pc_out
);

    logic [31:0]       fetch_pc_q, fetch_pc_d;
    IF_DP_PACKET [1:0] pkt_q, pkt_d;
    IF_DP_PACKET [1:0] ext_pkt;

    logic [31:0] slot_inst [2];
    logic [31:0] slot_pc   [2];
    logic [31:0] slot_npc  [2];
    logic [1:0]  slot_valid;
    logic [31:0] next_pc;
    logic        occupied;
    logic        advance;

    // A misaligned PC (bit 2 set) points at the upper word, which is the last in the line.
    assign slot_inst[0] = fetch_pc_q[2] ? Icache2proc_data[63:32] : Icache2proc_data[31:0];
    assign slot_inst[1] = Icache2proc_data[63:32];
    assign slot_pc[0]   = fetch_pc_q;
    assign slot_pc[1]   = fetch_pc_q + 32'd4;

`ifdef IF_JAL_PREDICT_EN
    logic [1:0]  is_jal;
    logic [31:0] jal_target [2];

    jal_predecode u_jal_slot0 (
        .inst_i   (slot_inst[0]),
        .pc_i     (slot_pc[0]),
        .is_jal_o (is_jal[0]),
        .target_o (jal_target[0])
    );

    jal_predecode u_jal_slot1 (
        .inst_i   (slot_inst[1]),
        .pc_i     (slot_pc[1]),
        .is_jal_o (is_jal[1]),
        .target_o (jal_target[1])
    );

    // A predicted-taken JAL in slot0 makes the sequential slot1 word dead.
    assign slot_valid  = {~fetch_pc_q[2] & ~is_jal[0], 1'b1};
    assign slot_npc[0] = is_jal[0] ? jal_target[0] : slot_pc[0] + 32'd4;
    assign slot_npc[1] = is_jal[1] ? jal_target[1] : slot_pc[1] + 32'd4;
`else
    assign slot_valid  = {~fetch_pc_q[2], 1'b1};
    assign slot_npc[0] = slot_pc[0] + 32'd4;
    assign slot_npc[1] = slot_pc[1] + 32'd4;
`endif

    assign next_pc  = slot_valid[1] ? slot_npc[1] : slot_npc[0];
    assign occupied = pkt_q[0].valid | pkt_q[1].valid;
    assign advance  = Icache2proc_valid & ~squash_in & (~buffer_full_in | ~occupied);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ext_pkt[i] = slot_valid[i] ? '{inst: slot_inst[i], PC: slot_pc[i], NPC: slot_npc[i], valid: 1'b1}
                                       : EMPTY_PKT;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        fetch_pc_d = fetch_pc_q;
        pkt_d      = pkt_q;
        if (squash_in) begin
            fetch_pc_d = squash_pc_in;
            pkt_d      = {EMPTY_PKT, EMPTY_PKT};
        end else if (advance) begin
            fetch_pc_d = next_pc;
            pkt_d      = ext_pkt;
        end else if (!buffer_full_in) begin
            // Miss with room downstream: the buffer took the old packets this edge.
            pkt_d      = {EMPTY_PKT, EMPTY_PKT};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            pkt_q      <= {EMPTY_PKT, EMPTY_PKT};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pkt_q      <= pkt_d;
        end
    end

    assign proc2Icache_addr = {fetch_pc_q[31:3], 3'b000};
    assign if_dp_packet_out = pkt_q;
    assign fetch_pc_out     = fetch_pc_q;

endmodule

// File: tb/tb_fetch_stage_2w.sv
// Self-checking bench for fetch_stage_2w: a table of per-cycle vectors plus a
// hand-written async-reset-during-stall sequence. Honours IF_JAL_PREDICT_EN.
module tb_fetch_stage_2w;
    import sys_defs::*;

    logic              clock;
    logic              reset_n;
    logic              squash_in;
    logic [31:0]       squash_pc_in;
    logic              buffer_full_in;
    logic [63:0]       Icache2proc_data;
    logic              Icache2proc_valid;
    logic [31:0]       proc2Icache_addr;
    IF_DP_PACKET [1:0] if_dp_packet_out;
    logic [31:0]       fetch_pc_out;

    fetch_stage_2w #(.RESET_PC(32'h0)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .squash_in         (squash_in),
        .squash_pc_in      (squash_pc_in),
        .buffer_full_in    (buffer_full_in),
        .Icache2proc_data  (Icache2proc_data),
        .Icache2proc_valid (Icache2proc_valid),
        .proc2Icache_addr  (proc2Icache_addr),
        .if_dp_packet_out  (if_dp_packet_out),
        .fetch_pc_out      (fetch_pc_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        squash;
        logic [31:0] squash_pc;
        logic        full;
        logic        hit;
        logic [63:0] data;
        logic [31:0] exp_fpc;
        IF_DP_PACKET exp0;
        IF_DP_PACKET exp1;
    } vec_t;

    localparam IF_DP_PACKET E = '{inst: 32'h0000_0013, PC: 32'h0, NPC: 32'h0, valid: 1'b0};

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic IF_DP_PACKET p(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] npc);
        return '{inst: inst, PC: pc, NPC: npc, valid: 1'b1};
    endfunction

    function automatic vec_t v(input logic sq, input logic [31:0] sq_pc, input logic full, input logic hit,
                               input logic [63:0] data, input logic [31:0] fpc,
                               input IF_DP_PACKET e0, input IF_DP_PACKET e1);
        vec_t r;
        r.squash = sq; r.squash_pc = sq_pc; r.full = full; r.hit = hit; r.data = data;
        r.exp_fpc = fpc; r.exp0 = e0; r.exp1 = e1;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [31:0] fpc, input IF_DP_PACKET e0, input IF_DP_PACKET e1);
        logic [31:0] exp_addr;
        exp_addr = {fpc[31:3], 3'b000};
        check({tag, ".fetch_pc"}, 128'(fetch_pc_out), 128'(fpc));
        check({tag, ".addr"},     128'(proc2Icache_addr), 128'(exp_addr));
        check({tag, ".slot0"},    128'(if_dp_packet_out[0]), 128'(e0));
        check({tag, ".slot1"},    128'(if_dp_packet_out[1]), 128'(e1));
    endtask

    task automatic drive(input vec_t x);
        squash_in         = x.squash;
        squash_pc_in      = x.squash_pc;
        buffer_full_in    = x.full;
        Icache2proc_valid = x.hit;
        Icache2proc_data  = x.data;
    endtask

    initial begin
        // Aligned fetch from reset, then a second line
        vecs.push_back(v(0, 0, 0, 1, {32'h0020_0093, 32'h0010_0093}, 32'h08,
                         p(32'h0010_0093, 32'h00, 32'h04), p(32'h0020_0093, 32'h04, 32'h08)));
        vecs.push_back(v(0, 0, 0, 1, {32'h0040_0193, 32'h0030_0113}, 32'h10,
                         p(32'h0030_0113, 32'h08, 32'h0C), p(32'h0040_0193, 32'h0C, 32'h10)));
        // Back-pressure for two cycles: packets and PC frozen
        vecs.push_back(v(0, 0, 1, 1, {32'hDEAD_0033, 32'hBEEF_0033}, 32'h10,
                         p(32'h0030_0113, 32'h08, 32'h0C), p(32'h0040_0193, 32'h0C, 32'h10)));
        vecs.push_back(v(0, 0, 1, 1, {32'hDEAD_0033, 32'hBEEF_0033}, 32'h10,
                         p(32'h0030_0113, 32'h08, 32'h0C), p(32'h0040_0193, 32'h0C, 32'h10)));
        vecs.push_back(v(0, 0, 0, 1, {32'h0060_0313, 32'h0050_0293}, 32'h18,
                         p(32'h0050_0293, 32'h10, 32'h14), p(32'h0060_0313, 32'h14, 32'h18)));
        // Misaligned redirect
        vecs.push_back(v(1, 32'h14, 0, 1, {32'h0060_0313, 32'h0050_0293}, 32'h14, E, E));
        vecs.push_back(v(0, 0, 0, 1, {32'h0080_0413, 32'h0070_0393}, 32'h18,
                         p(32'h0080_0413, 32'h14, 32'h18), E));
        // Three-cycle miss, then a hit
        vecs.push_back(v(0, 0, 0, 0, 64'h0, 32'h18, E, E));
        vecs.push_back(v(0, 0, 0, 0, 64'h0, 32'h18, E, E));
        vecs.push_back(v(0, 0, 0, 0, 64'h0, 32'h18, E, E));
        vecs.push_back(v(0, 0, 0, 1, {32'h00A0_0513, 32'h0090_0493}, 32'h20,
                         p(32'h0090_0493, 32'h18, 32'h1C), p(32'h00A0_0513, 32'h1C, 32'h20)));
        // JAL in slot0 at PC 0x20
`ifdef IF_JAL_PREDICT_EN
        vecs.push_back(v(0, 0, 0, 1, {32'h0010_0093, 32'h0100_00EF}, 32'h30,
                         p(32'h0100_00EF, 32'h20, 32'h30), E));
`else
        vecs.push_back(v(0, 0, 0, 1, {32'h0010_0093, 32'h0100_00EF}, 32'h28,
                         p(32'h0100_00EF, 32'h20, 32'h24), p(32'h0010_0093, 32'h24, 32'h28)));
`endif
        // Squash beats full and miss in the same cycle
        vecs.push_back(v(1, 32'h40, 1, 0, 64'h0, 32'h40, E, E));
        // Full asserted but output empty: still advances
        vecs.push_back(v(0, 0, 1, 1, {32'h00C0_0613, 32'h00B0_0593}, 32'h48,
                         p(32'h00B0_0593, 32'h40, 32'h44), p(32'h00C0_0613, 32'h44, 32'h48)));
        // PC wrap from 0xFFFF_FFFC to 0
        vecs.push_back(v(1, 32'hFFFF_FFFC, 0, 1, 64'h0, 32'hFFFF_FFFC, E, E));
        vecs.push_back(v(0, 0, 0, 1, {32'h00E0_0713, 32'h00D0_0693}, 32'h0,
                         p(32'h00E0_0713, 32'hFFFF_FFFC, 32'h0), E));

        // Reset state, checked with no clock edge needed
        reset_n = 1'b0;
        drive(v(0, 0, 0, 0, 64'h0, 0, E, E));
        #12;
        check_all("reset", 32'h0, E, E);

        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clock);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_fpc, vecs[i].exp0, vecs[i].exp1);
        end

        // Load from PC 0, stall, then reset asynchronously mid-stall
        drive(v(0, 0, 0, 1, {32'h0F00_0793, 32'h0F10_0813}, 0, E, E));
        @(posedge clock);
        #1;
        check_all("pre_stall", 32'h08, p(32'h0F10_0813, 32'h00, 32'h04), p(32'h0F00_0793, 32'h04, 32'h08));
        drive(v(0, 0, 1, 0, 64'h0, 0, E, E));
        @(posedge clock);
        #1;
        check_all("stall", 32'h08, p(32'h0F10_0813, 32'h00, 32'h04), p(32'h0F00_0793, 32'h04, 32'h08));
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_rst", 32'h0, E, E);
        @(negedge clock);
        reset_n = 1'b1;
        drive(v(0, 0, 0, 0, 64'h0, 0, E, E));
        @(posedge clock);
        #1;
        check_all("post_rst_miss", 32'h0, E, E);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
